// File: rtl/pipeline_exc_ctrl.sv
// pipeline_exc_ctrl: syscall/eret sequencer driving the late-ALU CP0 ops.
// Optional feature macro: EXC_CTRL_EXL_GUARD_EN (discard syscall while exl=1).
module pipeline_exc_ctrl #(
   parameter logic [31:0] HANDLER_VEC  = 32'h0000_0180,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_req,
   input  logic [31:0] exc_pc,
   input  logic        eret_req,
   input  logic [31:0] cpr14_in,
   output logic        ack,
   output logic        stall,
   output logic        flush,
   output logic [5:0]  alu_op,
   output logic [31:0] alu_a0,
   output logic [31:0] alu_a1,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        exl,
   output logic        exc_dropped
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE_SYS,
      DRAIN,
      ISSUE_ERET,
      REDIRECT
   } state_t;

   localparam logic [5:0] OP_SYS   = 6'b001000;
   localparam logic [5:0] OP_ERET  = 6'b001001;
   localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        kind_q, kind_d;
   logic [31:0] tgt_q, tgt_d;
   logic        exl_q, exl_d;
   logic        guard_hit;

`ifdef EXC_CTRL_EXL_GUARD_EN
   logic drop_q;
   assign guard_hit = exl_q;

   // One-cycle pulse after a syscall is swallowed at exception level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) drop_q <= 1'b0;
      else     drop_q <= (state_q == IDLE) & exc_req & exl_q;
   end

   assign exc_dropped = drop_q;
`else
   assign guard_hit   = 1'b0;
   assign exc_dropped = 1'b0;
`endif

   assign alu_a1 = 32'h0;
   assign exl    = exl_q;

   // State, drain counter, kind flag, latched target and exl mirror.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'h0;
         kind_q  <= 1'b0;
         tgt_q   <= 32'h0;
         exl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
         tgt_q   <= tgt_d;
         exl_q   <= exl_d;
      end
   end

   // Next-state and Moore outputs; kind_q=1 marks an eret sequence.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      kind_d         = kind_q;
      tgt_d          = tgt_q;
      exl_d          = exl_q;
      ack            = 1'b0;
      stall          = 1'b1;
      flush          = 1'b0;
      alu_op         = 6'b000000;
      alu_a0         = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      unique case (state_q)
         IDLE: begin
            stall = 1'b0;
            ack   = exc_req | eret_req;
            if (exc_req) begin
               if (!guard_hit) begin
                  state_d = ISSUE_SYS;
                  kind_d  = 1'b0;
                  tgt_d   = exc_pc;
               end
            end else if (eret_req) begin
               state_d = DRAIN;
               kind_d  = 1'b1;
               cnt_d   = CNT_INIT;
            end
         end
         ISSUE_SYS: begin
            flush   = 1'b1;
            alu_op  = OP_SYS;
            alu_a0  = tgt_q;
            exl_d   = 1'b1;
            state_d = DRAIN;
            cnt_d   = CNT_INIT;
         end
         DRAIN: begin
            flush = kind_q & (cnt_q == CNT_INIT);
            if (cnt_q == 4'h0) begin
               state_d = kind_q ? ISSUE_ERET : REDIRECT;
            end else begin
               cnt_d = cnt_q - 4'h1;
            end
         end
         ISSUE_ERET: begin
            alu_op  = OP_ERET;
            tgt_d   = cpr14_in;
            exl_d   = 1'b0;
            state_d = REDIRECT;
         end
         REDIRECT: begin
            redirect_valid = 1'b1;
            redirect_pc    = kind_q ? tgt_q : HANDLER_VEC;
            state_d        = IDLE;
         end
         default: begin
            stall   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: doc/pipeline_exc_ctrl.md
# pipeline_exc_ctrl

Exception sequencer that initiates the syscall and eret operations executed by the late ALU's CP0 registers. It accepts syscall/eret requests from the execute stage, stalls and flushes the pipeline, and issues the matching late-ALU op with the faulting PC. It then waits for in-flight CP0 writes to drain and redirects fetch, either to the handler vector or to the EPC (cpr14) read back from the late ALU.

## Interface
- HANDLER_VEC, 32'h0000_0180: fetch target after a syscall.
- DRAIN_CYCLES, 2: cycles waited for late-ALU writes to settle; legal range 1..15.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- exc_req  in  1  syscall detected; held by upstream until ack.
- exc_pc  in  32  PC of the syscall instruction; valid with exc_req.
- eret_req  in  1  eret detected; held by upstream until ack.
- cpr14_in  in  32  EPC from the late ALU (cpr14_out).
- ack  out  1  request accepted this cycle (combinational).
- stall  out  1  freeze fetch/decode.
- flush  out  1  kill younger instructions in flight.
- alu_op  out  6  op to late ALU: 6'b001000 syscall, 6'b001001 eret, else 6'b000000.
- alu_a0  out  32  late-ALU a0 (EPC for syscall, else 0).
- alu_a1  out  32  late-ALU a1, always 0.
- redirect_valid  out  1  one-cycle fetch redirect strobe.
- redirect_pc  out  32  redirect target.
- exl  out  1  local mirror of the exception-level bit (cpr12[1]).
- exc_dropped  out  1  one-cycle pulse when a syscall is discarded (see Configuration).

## Operation
- States: IDLE, ISSUE_SYS, DRAIN, ISSUE_ERET, REDIRECT. A 4-bit down-counter is used in DRAIN. A 1-bit kind flag (SYS/ERET) and 32-bit latched target/EPC registers are kept.
- IDLE: ack = exc_req | eret_req. When both requests are high, exc_req wins and eret_req stays pending (not acked).
- syscall: IDLE → ISSUE_SYS → DRAIN → REDIRECT → IDLE.
  - ISSUE_SYS drives alu_op=001000, alu_a0=latched exc_pc and flush=1, and sets exl on exit.
  - REDIRECT drives redirect_pc=HANDLER_VEC.
- eret: IDLE → DRAIN → ISSUE_ERET → REDIRECT → IDLE.
  - DRAIN runs first so that a preceding mtc0 to cpr14 has landed.
  - ISSUE_ERET drives alu_op=001001, latches cpr14_in as the target and clears exl on exit.
  - REDIRECT drives redirect_pc=latched EPC.
- DRAIN loads the counter with DRAIN_CYCLES-1 on entry and leaves when the counter is 0.
- stall=1 in every non-IDLE state. flush=1 only in ISSUE_SYS and in the first DRAIN cycle of an eret.
- Outside the issue states, alu_op=0 and alu_a0=0.
- Requests arriving while not in IDLE are not acked. They are evaluated again on return to IDLE.
- A syscall while exl=1 is taken normally and overwrites EPC (unless the Configuration macro is defined).

## Timing
- Reset state:
  - state=IDLE, exl=0, counter=0, latches=0.
  - All outputs 0, except ack, which follows its combinational definition.
- Syscall acked at cycle T:
  - ISSUE_SYS at T+1.
  - DRAIN at T+2..T+1+DRAIN_CYCLES.
  - REDIRECT at T+2+DRAIN_CYCLES.
  - IDLE at T+3+DRAIN_CYCLES.
- Eret acked at cycle T:
  - DRAIN at T+1..T+DRAIN_CYCLES.
  - ISSUE_ERET at T+1+DRAIN_CYCLES.
  - REDIRECT at T+2+DRAIN_CYCLES.
- A new request can be acked in the first IDLE cycle after REDIRECT.
- rst asserted mid-sequence forces IDLE immediately and clears exl. No redirect is emitted.

## Configuration
- EXC_CTRL_EXL_GUARD_EN defined:
  - A syscall acked while exl=1 is discarded: no ALU op, no stall, no redirect, and state stays IDLE.
  - exc_dropped pulses at T+1.
- Not defined: exc_dropped is tied to 0 and nested syscalls proceed normally.

## Test plan
- Reset then idle, with rst asserted asynchronously mid-cycle → all outputs 0 and exl=0 immediately, without waiting for a clock edge.
- exc_req=1, exc_pc=32'h0000_0404 at T, DRAIN_CYCLES=2 → ack at T; at T+1 alu_op=001000, alu_a0=32'h404, flush=1; redirect_valid=1 with redirect_pc=32'h180 at T+4; exl=1 from T+2.
- eret_req=1 at T with cpr14_in=32'h0000_0408 → ISSUE_ERET (alu_op=001001) at T+3; redirect_pc=32'h408 at T+4; exl=0 from T+4.
- exc_req and eret_req both high at T → only the syscall is acked at T; eret is acked at the first IDLE cycle (T+5), completing the sequence afterwards.
- rst pulse during DRAIN of a syscall → no redirect_valid; state is IDLE and exl=0 after release.
- With EXC_CTRL_EXL_GUARD_EN and exl=1, exc_req at T → ack at T; exc_dropped=1 at T+1; stall, alu_op and redirect_valid stay 0.
